// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, operand width and the divider FSM state type.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract the
// divisor magnitude and keep the difference when it did not borrow.
module div_step
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_next_o,
  output logic [DATA_W-1:0] quo_next_o
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] trial;
  logic              no_borrow;
  logic              unused_trial_bit;

  assign rem_sh = {rem_i, quo_i[DATA_W-1]};
  // Extra guard bit: the shifted remainder can exceed 2^DATA_W when the divisor MSB is set.
  assign trial     = {1'b0, rem_sh} - {2'b00, divisor_i};
  assign no_borrow = ~trial[DATA_W+1];

  assign rem_next_o = no_borrow ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_next_o = {quo_i[DATA_W-2:0], no_borrow};

  assign unused_trial_bit = trial[DATA_W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, result = {remainder, quotient}.
// Define SEQ_DIVIDER_SIGNED_EN to honour is_signed (DIV); otherwise every division is DIVU.
module seq_divider
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                div_by_zero
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DATA_W - 1);

  div_state_t            state_q, state_d;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]     dvd_q, dvs_q, rem_q, quo_q;
  logic [DATA_W-1:0]     rem_step, quo_step;
  logic [DATA_W-1:0]     dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [2*DATA_W-1:0]   result_q;
  logic                  done_q, dbz_q;
  logic                  accept;

  // The done cycle still counts as the tail of the operation, so a start there is dropped.
  assign accept = (state_q == IDLE) && start && !done_q;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn_q, q_neg_q, r_neg_q;

  assign dvd_mag = (sgn_q && dvd_q[DATA_W-1]) ? -dvd_q : dvd_q;
  assign dvs_mag = (sgn_q && dvs_q[DATA_W-1]) ? -dvs_q : dvs_q;
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      if (accept) begin
        sgn_q <= is_signed;
      end
      if (state_q == LOAD) begin
        q_neg_q <= sgn_q & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
        r_neg_q <= sgn_q & dvd_q[DATA_W-1];
      end
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag          = dvd_q;
  assign dvs_mag          = dvs_q;
  assign quo_fix          = quo_q;
  assign rem_fix          = rem_q;
`endif

  div_step u_step (
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .divisor_i  (dvs_q),
    .rem_next_o (rem_step),
    .quo_next_o (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        LOAD: begin
          // dvd_q keeps the original dividend for the divide-by-zero remainder.
          quo_q <= dvd_mag;
          dvs_q <= dvs_mag;
          rem_q <= '0;
          cnt_q <= '0;
        end
        ITER: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + DIV_CNT_W'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          if (dvs_q == '0) begin
            result_q <= {dvd_q, {DATA_W{1'b1}}};
            dbz_q    <= 1'b1;
          end else begin
            result_q <= {rem_fix, quo_fix};
            dbz_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, protocol/reset sequences
// and randomized operations checked against an arithmetic reference model.
module tb_seq_divider;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  localparam int LATENCY = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res;
  logic        last_dbz;
  logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division in 64-bit arithmetic, truncating toward zero.
  function automatic logic [64:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
    if (sgn && SIGNED_BUILD) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return $urandom_range(0, 20);
      1:       return 32'h0 - 32'($urandom_range(1, 20));
      2:       return corner[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int lat;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
    check({name, "/busy_after_start"}, 64'(busy), 64'd1);
    check({name, "/result_held"}, result, last_res);
    check({name, "/dbz_held"}, 64'(div_by_zero), 64'(last_dbz));
    wait_done(lat);
    check({name, "/latency"}, 64'(lat), 64'(LATENCY));
    check({name, "/quotient"}, 64'(result[31:0]), 64'(eq));
    check({name, "/remainder"}, 64'(result[63:32]), 64'(er));
    check({name, "/div_by_zero"}, 64'(div_by_zero), 64'(edbz));
    check({name, "/busy_at_done"}, 64'(busy), 64'd0);
    $display("op %-10s sgn=%0d %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
             name, sgn, a, b, result[31:0], result[63:32], div_by_zero, lat);
    last_res = {er, eq};
    last_dbz = edbz;
    step();
    check({name, "/done_pulse_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t        tbl [12];
    logic [64:0] m;
    logic [31:0] a, b;
    logic        sgn;
    int          lat;
    int          k;
    int          seen;

    tbl[0]  = '{"u100_7",    1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tbl[1]  = '{"u_dbz",     1'b0, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     1'b1};
    tbl[2]  = '{"s_dbz",     1'b1, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     1'b1};
    tbl[3]  = '{"s_dbz_neg", 1'b1, 32'hFFFFFF00, 32'h0,        32'hFFFFFFFF, 32'hFFFFFF00, 1'b1};
    tbl[4]  = '{"u_ovf",     1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    tbl[5]  = '{"u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
    tbl[6]  = '{"u7_100",    1'b0, 32'd7,        32'd100,      32'h0,        32'd7,        1'b0};
    tbl[7]  = '{"u_max_2",   1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'h1,        1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl[8]  = '{"s-100_7",   1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[9]  = '{"s100_-7",   1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    tbl[10] = '{"s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0};
    tbl[11] = '{"s-100_-7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
`else
    tbl[8]  = '{"s-100_7",   1'b1, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0};
    tbl[9]  = '{"s100_-7",   1'b1, 32'd100,      32'hFFFFFFF9, 32'h0,        32'd100,      1'b0};
    tbl[10] = '{"s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    tbl[11] = '{"s-100_-7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0,        32'hFFFFFF9C, 1'b0};
`endif

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    last_res  = '0;
    last_dbz  = 1'b0;
    step();
    step();
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/dbz", 64'(div_by_zero), 64'd0);
    check("reset/result", result, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].name, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);
    end

    // Protocol: starts at cycle 5 and in the done cycle are ignored, the next one is taken.
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    step();
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      k++;
      if (k == 5) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = 32'h0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("proto/latency", 64'(k), 64'(LATENCY));
    check("proto/result_a", result, {32'd2, 32'd14});
    check("proto/dbz_a", 64'(div_by_zero), 64'd0);
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = $urandom;
    divisor   = 32'h0;
    step();
    check("proto/start_in_done_busy", 64'(busy), 64'd0);
    check("proto/start_in_done_done", 64'(done), 64'd0);
    check("proto/result_a_held", result, {32'd2, 32'd14});
    is_signed = 1'b0;
    dividend  = 32'hFFFFFFFF;
    divisor   = 32'h10;
    step();
    start = 1'b0;
    check("proto/accept_after_done", 64'(busy), 64'd1);
    wait_done(lat);
    check("proto/latency_c", 64'(lat), 64'(LATENCY));
    check("proto/result_c", result, {32'hF, 32'h0FFFFFFF});
    $display("op %-10s sgn=0 ffffffff / 00000010 -> q=%h r=%h lat=%0d", "proto", result[31:0], result[63:32], lat);
    last_res = {32'hF, 32'h0FFFFFFF};
    last_dbz = 1'b0;
    step();

    // Reset at iteration 10, with start asserted alongside it.
    dividend = 32'h12345678;
    divisor  = 32'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/result", result, 64'd0);
    check("rst/dbz", 64'(div_by_zero), 64'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("rst/no_done_no_busy", 64'(seen), 64'd0);
    $display("op %-10s reset mid-operation, done/busy seen %0d times afterwards", "rst", seen);
    last_res = '0;
    last_dbz = 1'b0;
    run_op("post_rst", 1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a   = pick_operand();
      b   = pick_operand();
      m   = ref_div(sgn, a, b);
      run_op("rand", sgn, a, b, m[31:0], m[63:32], m[64]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
